tx_resp_arbiter: RTL and testbench
==================================

Name: tx_resp_arbiter

Overview:
- Shares the single write port of the REF_CLK-domain TX async FIFO between three response producers:
  - register-file read data (1 byte);
  - ALU results (2 bytes, LSB first);
  - a status/error byte source.
- Each source has a one-entry holding register that captures single-cycle valid pulses.
- A round-robin scheduler drains the holding registers into the FIFO under FIFO_FULL backpressure.
- Sits between the system controller/ALU outputs and the FIFO W_INC/WR_DATA inputs.

Parameters:
- DATA_WIDTH, 8, byte width of FIFO data and of RD/STS sources.
- ALU_OUT_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH.

Ports:
- CLK  input  1  REF_CLK domain clock.
- RST  input  1  asynchronous active-low reset.
- RD_DATA  input  DATA_WIDTH  register-file read byte.
- RD_DATA_VALID  input  1  one-cycle strobe for RD_DATA.
- ALU_OUT  input  ALU_OUT_WIDTH  ALU result.
- ALU_OUT_VALID  input  1  one-cycle strobe for ALU_OUT.
- STS_DATA  input  DATA_WIDTH  status byte.
- STS_VALID  input  1  one-cycle strobe for STS_DATA.
- FIFO_FULL  input  1  FIFO full flag, write-clock domain.
- WR_DATA  output  DATA_WIDTH  byte to FIFO, registered.
- W_INC  output  1  FIFO write strobe, registered, one cycle per byte.
- PEND  output  3  per-source holding-register occupied flags {STS, ALU, RD}.
- OVF  output  3  sticky per-source overflow flags {STS, ALU, RD}.
- OVF_CLR  input  1  synchronous clear of all OVF bits.
- BUSY  output  1  state != IDLE or any PEND bit set.

Behaviour:
- Reset (RST=0, asynchronous) drives these values immediately:
  - WR_DATA=0, W_INC=0, PEND=0, OVF=0, BUSY=0;
  - state=IDLE, byte index=0;
  - round-robin last-grant pointer=STS, so RD has first priority.
- Capture: on a rising edge with x_VALID=1:
  - PEND[x]=0, or PEND[x] is being cleared on this same edge → load the holding register and set PEND[x]. The new valid wins over the clear.
  - Otherwise → drop the data, set OVF[x] (sticky); the held data is unchanged.
- OVF_CLR=1 clears OVF on the next edge. A simultaneous overflow event on the same edge sets the bit, so set wins.
- FSM states are IDLE, SEND and GAP.
- IDLE:
  - If any PEND is set, grant the first pending source after the last-grant pointer, in cyclic order RD→ALU→STS.
  - Latch the grant, set byte index=0, update the pointer, go to SEND.
  - If nothing is pending, stay in IDLE.
- SEND:
  - If FIFO_FULL=0: at the edge, W_INC<=1 and WR_DATA<=selected byte, then go to GAP.
    - RD and STS send their held byte.
    - ALU sends ALU_OUT[7:0] at index 0 and ALU_OUT[15:8] at index 1.
  - If FIFO_FULL=1: W_INC<=0, WR_DATA holds, stay in SEND indefinitely.
- GAP:
  - W_INC<=0 for exactly one cycle, so writes are never back-to-back and FIFO_FULL always reflects the previous write.
  - If the grant is ALU and index=0: index<=1, return to SEND.
  - Otherwise return to IDLE.
- Pending clear: PEND[grant] clears on the edge that issues the grant's last byte write (entering GAP). The holding register is free from that edge on.
- Timing:
  - Single-byte latency: valid at edge 0 → grant at edge 1 → W_INC high after edge 2 (FIFO not full).
  - An ALU result produces W_INC pulses after edges 2 and 4.
  - The next grant is issued at the edge following the return to IDLE.
- Fairness: when all three sources are continuously pending, grants rotate RD, ALU, STS, RD, …
- Mid-operation: a held ALU byte 1 is never interleaved with another source's byte. A grant runs to completion.
- Reset mid-operation: the frame is abandoned and W_INC is deasserted asynchronously. A partially written ALU pair is not recovered.
- Holding registers are not reset-sensitive beyond PEND; data content after reset is don't-care.

Test Plan:
- Single RD: RD_DATA=0xA5 pulsed, FIFO_FULL=0 → exactly one W_INC, WR_DATA=0xA5, W_INC high in the cycle after the second edge post-strobe; PEND returns to 0, BUSY drops.
- ALU split: ALU_OUT=0x1234 pulsed → two W_INC pulses separated by one idle cycle, bytes 0x34 then 0x12; no other source is interleaved even if RD_DATA_VALID (0x77) arrives between them; 0x77 is written third.
- Round robin: RD=0x01, ALU=0xBEEF and STS=0x0F pulsed on the same edge → FIFO byte order 0x01, 0xEF, 0xBE, 0x0F; after reset, repeating with only ALU and STS gives ALU first.
- Backpressure: FIFO_FULL=1 held 10 cycles during SEND for RD=0x5A → no W_INC during the stall; a single W_INC with 0x5A on the first edge after FULL falls.
- Overflow: FIFO_FULL=1, STS pulsed 0x11 then 0x22 → only 0x11 delivered after FULL falls; OVF[2]=1 stays set until OVF_CLR; OVF_CLR together with a third overflow leaves OVF[2]=1.
- Async reset: RST asserted between the two ALU bytes → W_INC, PEND, OVF and BUSY go to 0 immediately; after release, a new RD=0x3C is delivered normally with RD-first priority.

Source files
------------

// File: rtl/tx_resp_arbiter.sv
// Arbitrates RD / ALU / STS response producers onto the single TX FIFO write port.
// One-entry holding register per source, round-robin grant, one idle cycle after every write.
module tx_resp_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 2*DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     RD_DATA_VALID,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  input  logic [DATA_WIDTH-1:0]    STS_DATA,
  input  logic                     STS_VALID,
  input  logic                     FIFO_FULL,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     W_INC,
  output logic [2:0]               PEND,
  output logic [2:0]               OVF,
  input  logic                     OVF_CLR,
  output logic                     BUSY
);

  localparam logic [1:0] SRC_RD  = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_STS = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               grant_q, grant_d;
  logic [1:0]               last_q, last_d;
  logic                     idx_q, idx_d;
  logic [2:0]               pend_q, pend_d;
  logic [2:0]               ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     w_inc_q, w_inc_d;
  logic [DATA_WIDTH-1:0]    hold_rd_q, hold_sts_q;
  logic [ALU_OUT_WIDTH-1:0] hold_alu_q;

  logic [2:0]            vld, load, pend_clr;
  logic [1:0]            pick, cand;
  logic                  found, last_byte, write_go;
  logic [DATA_WIDTH-1:0] sel_byte;

  function automatic logic [1:0] nxt(input logic [1:0] s);
    return (s == SRC_STS) ? SRC_RD : s + 2'd1;
  endfunction

  // First pending source strictly after the last grant, cyclic RD->ALU->STS.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = nxt(cand);
      if (!found && pend_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (grant_q)
      SRC_ALU: sel_byte = idx_q ? hold_alu_q[ALU_OUT_WIDTH-1:DATA_WIDTH]
                                : hold_alu_q[DATA_WIDTH-1:0];
      SRC_STS: sel_byte = hold_sts_q;
      default: sel_byte = hold_rd_q;
    endcase
  end

  assign last_byte = (grant_q != SRC_ALU) || idx_q;
  assign write_go  = (state_q == SEND) && !FIFO_FULL;
  assign pend_clr  = (write_go && last_byte) ? (3'b001 << grant_q) : 3'b000;

  // A new strobe may reuse a slot freed on the same edge; otherwise it overflows.
  assign vld    = {STS_VALID, ALU_OUT_VALID, RD_DATA_VALID};
  assign load   = vld & (~pend_q | pend_clr);
  assign pend_d = (pend_q & ~pend_clr) | load;
  assign ovf_d  = (OVF_CLR ? 3'b000 : ovf_q) | (vld & ~load);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    idx_d     = idx_q;
    wr_data_d = wr_data_q;
    w_inc_d   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        last_d  = pick;
        idx_d   = 1'b0;
        state_d = SEND;
      end
      SEND: if (!FIFO_FULL) begin
        w_inc_d   = 1'b1;
        wr_data_d = sel_byte;
        state_d   = GAP;
      end
      GAP: begin
        if (grant_q == SRC_ALU && !idx_q) begin
          idx_d   = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      grant_q   <= SRC_RD;
      last_q    <= SRC_STS;
      idx_q     <= 1'b0;
      pend_q    <= '0;
      ovf_q     <= '0;
      wr_data_q <= '0;
      w_inc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      wr_data_q <= wr_data_d;
      w_inc_q   <= w_inc_d;
    end
  end

  // Holding data is qualified by PEND, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (load[0]) hold_rd_q  <= RD_DATA;
    if (load[1]) hold_alu_q <= ALU_OUT;
    if (load[2]) hold_sts_q <= STS_DATA;
  end

  assign WR_DATA = wr_data_q;
  assign W_INC   = w_inc_q;
  assign PEND    = pend_q;
  assign OVF     = ovf_q;
  assign BUSY    = (state_q != IDLE) || (|pend_q);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Bench for tx_resp_arbiter: transaction-level reference model feeding a scoreboard,
// directed scenarios followed by a randomized soak.
module tb_tx_resp_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RD_DATA = '0;
  logic        RD_DATA_VALID = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  STS_DATA = '0;
  logic        STS_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        OVF_CLR = 1'b0;
  logic [7:0]  WR_DATA;
  logic        W_INC;
  logic [2:0]  PEND, OVF;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .STS_DATA(STS_DATA), .STS_VALID(STS_VALID),
    .FIFO_FULL(FIFO_FULL),
    .WR_DATA(WR_DATA), .W_INC(W_INC),
    .PEND(PEND), .OVF(OVF), .OVF_CLR(OVF_CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-source slots plus the byte list of the frame in flight.
  bit   [2:0]  m_pend;
  logic [15:0] m_held [3];
  bit   [2:0]  m_ovf;
  bit          m_active, m_gap, m_winc;
  int          m_src, m_last;
  logic [7:0]  m_frame [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  wlog [$];
  logic [7:0]  exp_log [$];

  always @(posedge CLK or negedge RST) begin : model
    int clr;
    bit [2:0] vin, evt;
    logic [15:0] din [3];
    int s;
    if (!RST) begin
      m_pend = '0; m_ovf = '0; m_active = 0; m_gap = 0; m_winc = 0;
      m_last = 2; m_src = 0;
      m_frame.delete();
      exp_q.delete();
    end else begin
      clr = -1; evt = '0; m_winc = 0;
      vin = {STS_VALID, ALU_OUT_VALID, RD_DATA_VALID};
      din[0] = {8'h00, RD_DATA}; din[1] = ALU_OUT; din[2] = {8'h00, STS_DATA};
      if (m_active && !m_gap) begin
        if (!FIFO_FULL) begin
          exp_q.push_back(m_frame.pop_front());
          m_winc = 1; m_gap = 1;
          if (m_frame.size() == 0) clr = m_src;
        end
      end else if (m_active) begin
        m_gap = 0;
        if (m_frame.size() == 0) m_active = 0;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          s = (m_last + k) % 3;
          if (!m_active && m_pend[s]) begin m_src = s; m_active = 1; end
        end
        if (m_active) begin
          m_last = m_src;
          m_frame.delete();
          m_frame.push_back(m_held[m_src][7:0]);
          if (m_src == 1) m_frame.push_back(m_held[1][15:8]);
        end
      end
      if (clr >= 0) m_pend[clr] = 0;
      for (int j = 0; j < 3; j++)
        if (vin[j]) begin
          if (!m_pend[j]) begin m_held[j] = din[j]; m_pend[j] = 1; end
          else evt[j] = 1;
        end
      if (OVF_CLR) m_ovf = '0;
      m_ovf |= evt;
    end
  end

  // Monitor: compares every cycle away from the active edge, pops the scoreboard on writes.
  always @(negedge CLK) begin
    if (RST) begin
      chk("w_inc", W_INC, m_winc);
      chk("pend", PEND, m_pend);
      chk("ovf", OVF, m_ovf);
      chk("busy", BUSY, m_active || (|m_pend));
      if (W_INC) begin
        wlog.push_back(WR_DATA);
        chk("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wr_data", WR_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
    RD_DATA_VALID = 0; ALU_OUT_VALID = 0; STS_VALID = 0; OVF_CLR = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RST = 0; FIFO_FULL = 0;
    ticks(2);
    RST = 1;
    tick();
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, wlog.size(), exp_log.size());
    for (int i = 0; i < wlog.size() && i < exp_log.size(); i++)
      chk({nm, "_byte"}, wlog[i], exp_log[i]);
  endtask

  initial begin
    ticks(2);
    chk("rst_w_inc", W_INC, 0);
    chk("rst_wr_data", WR_DATA, 0);
    chk("rst_pend", PEND, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1;
    tick();

    // Single RD byte, exact latency.
    wlog.delete();
    RD_DATA = 8'hA5; RD_DATA_VALID = 1; tick();
    chk("rd_pend", PEND, 3'b001);
    tick();
    chk("rd_no_early", W_INC, 0);
    tick();
    chk("rd_winc", W_INC, 1);
    chk("rd_data", WR_DATA, 8'hA5);
    tick();
    chk("rd_winc_drop", W_INC, 0);
    ticks(3);
    chk("rd_pend_clr", PEND, 0);
    chk("rd_idle", BUSY, 0);
    exp_log = '{8'hA5}; chk_log("rd");

    // ALU split with an RD arriving between the two bytes.
    wlog.delete();
    ALU_OUT = 16'h1234; ALU_OUT_VALID = 1; tick();
    ticks(2);
    RD_DATA = 8'h77; RD_DATA_VALID = 1; tick();
    ticks(8);
    exp_log = '{8'h34, 8'h12, 8'h77}; chk_log("alu");

    // Round robin from simultaneous strobes.
    do_reset(); wlog.delete();
    RD_DATA = 8'h01; RD_DATA_VALID = 1;
    ALU_OUT = 16'hBEEF; ALU_OUT_VALID = 1;
    STS_DATA = 8'h0F; STS_VALID = 1;
    tick(); ticks(14);
    exp_log = '{8'h01, 8'hEF, 8'hBE, 8'h0F}; chk_log("rr");
    do_reset(); wlog.delete();
    ALU_OUT = 16'hBEEF; ALU_OUT_VALID = 1;
    STS_DATA = 8'h0F; STS_VALID = 1;
    tick(); ticks(12);
    exp_log = '{8'hEF, 8'hBE, 8'h0F}; chk_log("rr2");

    // Backpressure stall in SEND.
    wlog.delete();
    FIFO_FULL = 1;
    RD_DATA = 8'h5A; RD_DATA_VALID = 1; tick();
    ticks(11);
    chk("bp_stall_len", wlog.size(), 0);
    chk("bp_busy", BUSY, 1);
    FIFO_FULL = 0; tick();
    chk("bp_winc", W_INC, 1);
    chk("bp_data", WR_DATA, 8'h5A);
    tick();
    chk("bp_single", W_INC, 0);
    ticks(3);

    // Overflow and sticky OVF with set-wins clear.
    wlog.delete();
    FIFO_FULL = 1;
    STS_DATA = 8'h11; STS_VALID = 1; tick();
    ticks(2);
    STS_DATA = 8'h22; STS_VALID = 1; tick();
    chk("ovf_set", OVF, 3'b100);
    FIFO_FULL = 0; ticks(6);
    exp_log = '{8'h11}; chk_log("ovf");
    chk("ovf_sticky", OVF, 3'b100);
    FIFO_FULL = 1;
    STS_DATA = 8'h33; STS_VALID = 1; tick();
    tick();
    STS_DATA = 8'h44; STS_VALID = 1; OVF_CLR = 1; tick();
    chk("ovf_set_wins", OVF, 3'b100);
    OVF_CLR = 1; tick();
    chk("ovf_cleared", OVF, 3'b000);
    FIFO_FULL = 0; ticks(6);
    exp_log = '{8'h11, 8'h33}; chk_log("ovf2");

    // Asynchronous reset between ALU bytes.
    wlog.delete();
    ALU_OUT = 16'h1234; ALU_OUT_VALID = 1; tick();
    ALU_OUT = 16'h9999; ALU_OUT_VALID = 1; tick();
    tick();
    chk("ar_first", W_INC, 1);
    chk("ar_ovf", OVF, 3'b010);
    #2 RST = 0;
    #1;
    chk("ar_w_inc", W_INC, 0);
    chk("ar_pend", PEND, 0);
    chk("ar_ovf0", OVF, 0);
    chk("ar_busy", BUSY, 0);
    ticks(2);
    RST = 1; tick();
    wlog.delete();
    RD_DATA = 8'h3C; RD_DATA_VALID = 1;
    STS_DATA = 8'h55; STS_VALID = 1;
    tick(); ticks(8);
    exp_log = '{8'h3C, 8'h55}; chk_log("ar_after");

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) FIFO_FULL = ~FIFO_FULL;
      RD_DATA = 8'($urandom);  RD_DATA_VALID = ($urandom_range(0, 4) == 0);
      ALU_OUT = 16'($urandom); ALU_OUT_VALID = ($urandom_range(0, 5) == 0);
      STS_DATA = 8'($urandom); STS_VALID = ($urandom_range(0, 4) == 0);
      OVF_CLR = ($urandom_range(0, 19) == 0);
      tick();
    end
    FIFO_FULL = 0;
    ticks(30);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_idle", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
